// File: rtl/gcd_pkg.sv
// gcd_pkg
// Shared types and constants for the GCD dispatcher slice.
//   state_t        : dispatcher FSM states (IDLE, ISSUE, WAIT, PUSH)
//   DATA_W_DEFAULT : default operand/result width, matches the engine
//   result_t       : layout of one result FIFO entry {err, r} at default width
package gcd_pkg;

  localparam int DATA_W_DEFAULT = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    PUSH  = 2'd3
  } state_t;

  typedef struct packed {
    logic                      err;
    logic [DATA_W_DEFAULT-1:0] r;
  } result_t;

endpackage

// File: rtl/gcd_result_fifo.sv
// gcd_result_fifo
// Synchronous in-order FIFO holding finished results.
//   clk, rst_n : clock, synchronous active-low reset (empties the FIFO)
//   wr_en, din : push request and data; accepted when not full, or when full
//                and a pop happens in the same cycle
//   rd_en      : pop request; ignored while empty
//   dout       : head entry, forced to zero while empty
//   full, empty, count : occupancy status
module gcd_result_fifo
  import gcd_pkg::*;
#(
  parameter int WIDTH = 33,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       wr_en,
  input  logic [WIDTH-1:0]           din,
  input  logic                       rd_en,
  output logic [WIDTH-1:0]           dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = rd_en && !empty;
  assign do_push = wr_en && (!full || do_pop);
  assign dout    = empty ? '0 : mem[rd_ptr];

  // Storage array: written only on an accepted push, never reset because
  // the empty flag masks stale contents on dout.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  // Pointers and occupancy. DEPTH is a power of two so the pointers wrap
  // naturally; a simultaneous push and pop leaves the count unchanged.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/gcd_dispatcher.sv
// gcd_dispatcher
// Feeds operand pairs to the start/ready/done GCD engine one at a time,
// answers zero-operand pairs locally, guards each engine run with a
// watchdog and queues results in order.
//   clk, rst_n                      : clock, synchronous active-low reset
//   in_valid/in_ready/in_a/in_b     : operand pair input stream
//   out_valid/out_ready/out_r/out_err : result output stream (FIFO head)
//   core_start/core_a/core_b        : engine request (one-cycle start pulse)
//   core_ready/core_done/core_r     : engine status and result
//   busy                            : a pair is being processed
//   timeout_flag/clr_flag           : sticky watchdog indication and its clear
module gcd_dispatcher
  import gcd_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEFAULT,
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 1023
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_r,
  output logic              out_err,
  output logic              core_start,
  output logic [DATA_W-1:0] core_a,
  output logic [DATA_W-1:0] core_b,
  input  logic              core_ready,
  input  logic              core_done,
  input  logic [DATA_W-1:0] core_r,
  output logic              busy,
  output logic              timeout_flag,
  input  logic              clr_flag
);

  localparam int TW = $clog2(TIMEOUT+1);
  localparam int CW = $clog2(FIFO_DEPTH+1);

  state_t            state;
  state_t            state_n;
  logic [TW-1:0]     timer;
  logic [DATA_W-1:0] res_r;
  logic              res_err;
  logic              push_q;
  logic              xfer;
  logic              is_zero;
  logic              wd_expired;
  logic [CW:0]       occupancy;

  logic              fifo_wr;
  logic [DATA_W:0]   fifo_dout;
  logic              fifo_full;
  logic              fifo_empty;
  logic [CW-1:0]     fifo_count;

  assign xfer       = in_valid && in_ready;
  assign is_zero    = (in_a == '0) || (in_b == '0);
  assign wd_expired = (timer == TW'(TIMEOUT-1));
  assign busy       = (state != IDLE);

  // The result written in PUSH lands in the FIFO one edge later, so the
  // pending entry counts against free space when admitting a new pair.
  assign occupancy  = {1'b0, fifo_count} + {{CW{1'b0}}, push_q};
  assign in_ready   = (state == IDLE) && (occupancy < (CW+1)'(FIFO_DEPTH));

  assign fifo_wr    = push_q && (!fifo_full || (out_valid && out_ready));
  assign out_valid  = !fifo_empty;
  assign out_err    = fifo_dout[DATA_W];
  assign out_r      = fifo_dout[DATA_W-1:0];

  // Next-state logic and the start pulse. Zero operands skip the engine
  // since it never terminates on them; ISSUE waits for the engine as long
  // as it takes, only WAIT is guarded by the watchdog, and a done pulse
  // beats an expiring watchdog in the same cycle.
  always_comb begin
    state_n    = state;
    core_start = 1'b0;
    case (state)
      IDLE: begin
        if (xfer) begin
          state_n = is_zero ? PUSH : ISSUE;
        end
      end
      ISSUE: begin
        core_start = core_ready;
        if (core_ready) begin
          state_n = WAIT;
        end
      end
      WAIT: begin
        if (core_done || wd_expired) begin
          state_n = PUSH;
        end
      end
      PUSH: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Operand latch, result capture, watchdog timer, deferred FIFO write and
  // the sticky timeout flag (a new timeout beats a clear in the same cycle).
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      core_a       <= '0;
      core_b       <= '0;
      res_r        <= '0;
      res_err      <= 1'b0;
      timer        <= '0;
      push_q       <= 1'b0;
      timeout_flag <= 1'b0;
    end else begin
      push_q <= (state == PUSH);
      if (clr_flag) begin
        timeout_flag <= 1'b0;
      end
      case (state)
        IDLE: begin
          if (xfer) begin
            core_a  <= in_a;
            core_b  <= in_b;
            res_r   <= in_a | in_b;
            res_err <= 1'b0;
          end
        end
        ISSUE: begin
          if (core_ready) begin
            timer <= '0;
          end
        end
        WAIT: begin
          timer <= timer + 1'b1;
          if (core_done) begin
            res_r   <= core_r;
            res_err <= 1'b0;
          end else if (wd_expired) begin
            res_r        <= '0;
            res_err      <= 1'b1;
            timeout_flag <= 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  gcd_result_fifo #(
    .WIDTH (DATA_W + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .wr_en (fifo_wr),
    .din   ({res_err, res_r}),
    .rd_en (out_ready),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

endmodule

// File: tb/tb_gcd_dispatcher.sv
// tb_gcd_dispatcher
// Directed bench for gcd_dispatcher with a behavioural engine model whose
// latency, readiness and completion can be steered per test.
module tb_gcd_dispatcher;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_r;
  logic        out_err;
  logic        core_start;
  logic [31:0] core_a;
  logic [31:0] core_b;
  logic        core_ready;
  logic        core_done;
  logic [31:0] core_r;
  logic        busy;
  logic        timeout_flag;
  logic        clr_flag;

  int total;
  int bad;
  int starts;

  logic        eng_busy;
  int          eng_cnt;
  logic        eng_done;
  logic [31:0] eng_r;
  int          eng_lat;
  logic        ready_en;
  logic        no_done;
  logic        inj_done;

  gcd_dispatcher #(
    .DATA_W     (32),
    .FIFO_DEPTH (4),
    .TIMEOUT    (16)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_a         (in_a),
    .in_b         (in_b),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_r        (out_r),
    .out_err      (out_err),
    .core_start   (core_start),
    .core_a       (core_a),
    .core_b       (core_b),
    .core_ready   (core_ready),
    .core_done    (core_done),
    .core_r       (core_r),
    .busy         (busy),
    .timeout_flag (timeout_flag),
    .clr_flag     (clr_flag)
  );

  // 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop in case something hangs despite the bounded waits.
  initial begin
    #500000;
    $display("[TB] FAIL global_timeout: simulation did not finish");
    $fatal(1, "[TB] global timeout");
  end

  function automatic logic [31:0] refGcd(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] x;
    logic [31:0] y;
    logic [31:0] t;
    x = a;
    y = b;
    while (y != 0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return x;
  endfunction

  // Engine model: idles with core_ready high, runs eng_lat+1 cycles after a
  // start and then pulses done, unless no_done suppresses the pulse.
  // inj_done lets the bench fire a stray done with a bogus result.
  assign core_ready = !eng_busy && ready_en;
  assign core_done  = eng_done || inj_done;
  assign core_r     = inj_done ? 32'd99 : eng_r;

  always @(posedge clk) begin
    eng_done <= 1'b0;
    if (!rst_n) begin
      eng_busy <= 1'b0;
      eng_cnt  <= 0;
      eng_r    <= '0;
    end else if (eng_busy) begin
      if (eng_cnt == 0) begin
        eng_busy <= 1'b0;
        eng_done <= !no_done;
      end else begin
        eng_cnt <= eng_cnt - 1;
      end
    end else if (core_start) begin
      eng_busy <= 1'b1;
      eng_cnt  <= eng_lat;
      eng_r    <= refGcd(core_a, core_b);
    end
  end

  // Counts start pulses seen by the engine interface.
  always @(posedge clk) begin
    if (core_start) begin
      starts <= starts + 1;
    end
  end

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, actual, expected);
    end
  endtask

  // Offers a pair and returns at the falling edge right after the transfer.
  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b);
    int n;
    n = 0;
    @(negedge clk);
    in_a     = a;
    in_b     = b;
    in_valid = 1'b1;
    while (!in_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checkOutput("xfer_wait", 0, 1);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Waits for a result, checks it, then pops it.
  task automatic expectResult(input string tag, input logic [31:0] r, input logic err);
    int n;
    n = 0;
    while (!out_valid && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!out_valid) begin
      checkOutput({tag, "_valid"}, 0, 1);
      return;
    end
    checkOutput(tag, out_r, r);
    checkOutput({tag, "_err"}, out_err, err);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Counts falling edges with busy high, starting at the current one.
  task automatic countBusy(output int cnt);
    cnt = 0;
    while (busy && cnt < 100) begin
      cnt++;
      @(negedge clk);
    end
  endtask

  initial begin
    int n;
    int bad_hold;
    int idle_hold;
    total     = 0;
    bad       = 0;
    starts    = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    out_ready = 1'b0;
    clr_flag  = 1'b0;
    eng_lat   = 3;
    ready_en  = 1'b1;
    no_done   = 1'b0;
    inj_done  = 1'b0;

    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_in_ready", in_ready, 1);
    checkOutput("rst_out_valid", out_valid, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_core_start", core_start, 0);
    checkOutput("rst_core_a", core_a, 0);
    checkOutput("rst_core_b", core_b, 0);
    checkOutput("rst_out_r", out_r, 0);
    checkOutput("rst_out_err", out_err, 0);
    checkOutput("rst_tflag", timeout_flag, 0);
    rst_n = 1'b1;

    // Engine path.
    $display("[TB] engine path");
    applyStimulus(32'd48, 32'd18);
    checkOutput("eng_core_a", core_a, 48);
    checkOutput("eng_core_b", core_b, 18);
    checkOutput("eng_start_now", core_start, 1);
    expectResult("gcd_48_18", 32'd6, 1'b0);
    checkOutput("eng_start_cnt", starts, 1);
    applyStimulus(32'd17, 32'd5);
    expectResult("gcd_17_5", 32'd1, 1'b0);
    checkOutput("eng_start_cnt2", starts, 2);

    // Zero bypass, with the two-edge output latency.
    $display("[TB] zero bypass");
    applyStimulus(32'd0, 32'd35);
    checkOutput("byp_valid_t1", out_valid, 0);
    @(negedge clk);
    checkOutput("byp_valid_t2", out_valid, 0);
    @(negedge clk);
    checkOutput("byp_valid_t3", out_valid, 1);
    applyStimulus(32'd42, 32'd0);
    applyStimulus(32'd0, 32'd0);
    expectResult("byp_0_35", 32'd35, 1'b0);
    expectResult("byp_42_0", 32'd42, 1'b0);
    expectResult("byp_0_0", 32'd0, 1'b0);
    checkOutput("byp_no_start", starts, 2);

    // Backpressure: fill the FIFO, then push and pop in the same cycle.
    $display("[TB] backpressure");
    applyStimulus(32'd7, 32'd3);
    applyStimulus(32'd4, 32'd6);
    applyStimulus(32'd9, 32'd12);
    applyStimulus(32'd8, 32'd12);
    waitCycles(15);
    checkOutput("full_in_ready", in_ready, 0);
    checkOutput("full_busy", busy, 0);
    expectResult("bp_r1", 32'd1, 1'b0);
    applyStimulus(32'd0, 32'd5);
    @(negedge clk);
    checkOutput("bp_head_hold", out_r, 2);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checkOutput("bp_head_after", out_r, 3);
    checkOutput("bp_pushpop_ready", in_ready, 1);
    applyStimulus(32'd12, 32'd18);
    waitCycles(15);
    checkOutput("bp_refull_ready", in_ready, 0);
    expectResult("bp_r3", 32'd3, 1'b0);
    expectResult("bp_r4", 32'd4, 1'b0);
    expectResult("bp_r5", 32'd5, 1'b0);
    expectResult("bp_r6", 32'd6, 1'b0);
    checkOutput("bp_drained", out_valid, 0);

    // Watchdog: engine never completes.
    $display("[TB] watchdog");
    no_done = 1'b1;
    applyStimulus(32'd9, 32'd6);
    countBusy(n);
    checkOutput("to_busy_len", n, 18);
    expectResult("to_result", 32'd0, 1'b1);
    checkOutput("to_flag", timeout_flag, 1);
    waitCycles(5);
    checkOutput("to_flag_sticky", timeout_flag, 1);
    clr_flag = 1'b1;
    @(negedge clk);
    clr_flag = 1'b0;
    checkOutput("to_flag_clr", timeout_flag, 0);

    // Done on the last watchdog cycle wins.
    no_done = 1'b0;
    eng_lat = 14;
    applyStimulus(32'd9, 32'd6);
    countBusy(n);
    checkOutput("edge_busy_len", n, 18);
    expectResult("edge_result", 32'd3, 1'b0);
    checkOutput("edge_flag", timeout_flag, 0);

    // Done one cycle too late: timeout, and the late done is dropped.
    eng_lat = 15;
    applyStimulus(32'd9, 32'd6);
    expectResult("late_result", 32'd0, 1'b1);
    waitCycles(5);
    checkOutput("late_no_extra", out_valid, 0);
    checkOutput("late_flag", timeout_flag, 1);
    clr_flag = 1'b1;
    @(negedge clk);
    clr_flag = 1'b0;
    eng_lat = 3;

    // Engine not ready: start waits.
    $display("[TB] engine not ready");
    ready_en = 1'b0;
    applyStimulus(32'd20, 32'd8);
    bad_hold  = 0;
    idle_hold = 0;
    for (int i = 0; i < 10; i++) begin
      if (core_start) bad_hold++;
      if (!busy) idle_hold++;
      @(negedge clk);
    end
    checkOutput("hold_no_start", bad_hold, 0);
    checkOutput("hold_busy", idle_hold, 0);
    ready_en = 1'b1;
    #1;
    checkOutput("hold_start_now", core_start, 1);
    @(negedge clk);
    expectResult("hold_result", 32'd4, 1'b0);

    // Reset in WAIT with two results buffered.
    $display("[TB] reset mid-run");
    applyStimulus(32'd0, 32'd11);
    applyStimulus(32'd0, 32'd13);
    no_done = 1'b1;
    applyStimulus(32'd9, 32'd6);
    waitCycles(2);
    checkOutput("mid_busy", busy, 1);
    rst_n = 1'b0;
    @(negedge clk);
    checkOutput("mid_rst_valid", out_valid, 0);
    checkOutput("mid_rst_ready", in_ready, 1);
    checkOutput("mid_rst_busy", busy, 0);
    rst_n    = 1'b1;
    inj_done = 1'b1;
    @(negedge clk);
    inj_done = 1'b0;
    waitCycles(5);
    checkOutput("mid_late_valid", out_valid, 0);
    checkOutput("mid_late_busy", busy, 0);
    no_done = 1'b0;
    applyStimulus(32'd100, 32'd75);
    expectResult("mid_gcd_100_75", 32'd25, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
